// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the decode stage and its register file.
//   XLEN / NREGS   datapath width and architectural register count
//   opcode values  OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC
//   alu_op_e       4-bit ALU operation code handed to execute
//   id_ex_t        contents of the ID/EX pipeline register
//   alu_op_decode  funct3/funct7 to ALU operation mapping
package rv32i_pkg;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int REG_AW  = $clog2(NREGS);

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10   // result = operand B (LUI)
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    alu_op_e           alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              branch;
    logic              jump;
    logic [2:0]        funct3;
  } id_ex_t;

  // is_reg distinguishes R-type (bit30 selects SUB) from OP_IMM, where bit30
  // is immediate data except for the SRAI/SRLI selector.
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3,
                                            input logic       bit30,
                                            input logic       is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 2 asynchronous read ports, 1 write port.
//   stage_clk, reset_n     clock / async active-low reset (clears all entries)
//   rs1_addr, rs1_data     read port 1
//   rs2_addr, rs2_data     read port 2
//   wb_we, wb_rd, wb_data  write port, written on the rising edge
// x0 reads as zero and ignores writes. A write in flight is forwarded to a
// read of the same register in the same cycle.
module reg_file
  import rv32i_pkg::*;
(
  input  logic              stage_clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs1_data,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = wb_we && (wb_rd != '0);

  // NOTE: the register file must read as zero after reset, so every entry is
  // cleared in the reset branch; an unreset array would come up as X.
  always_ff @(posedge stage_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)                      rs1_data = '0;
    else if (wr_en && (wb_rd == rs1_addr))   rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)                      rs2_data = '0;
    else if (wr_en && (wb_rd == rs2_addr))   rs2_data = wb_data;
  end

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: decodes instr_in, reads the register file, builds the
// immediate and registers everything into the ID/EX register.
//   stage_clk, reset_n        clock / async active-low reset
//   stage_ena                 1: ID/EX may update, 0: hold
//   stage_x                   synchronous flush, inserts a bubble
//   instr_in, pc_in           instruction and its PC from fetch
//   wb_we, wb_rd, wb_data     register file write port from writeback
//   hazard_stall              combinational load-use stall request to fetch
//   ex_*                      ID/EX register contents for execute
module decode_unit
  import rv32i_pkg::*;
(
  input  logic              stage_clk,
  input  logic              reset_n,
  input  logic              stage_ena,
  input  logic              stage_x,
  input  logic [XLEN-1:0]   instr_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [2:0]        ex_funct3
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
  logic              uses_rs1, uses_rs2;
  id_ex_t            dec, id_ex_next, ex_q;
  logic [XLEN-1:0]   rs1_data, rs2_data;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];

  assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                  instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u = {instr_in[31:12], 12'b0};
  assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                  instr_in[20], instr_in[30:21], 1'b0};

  // Control decode. Unknown opcodes (including the all-zero flush word) keep
  // the all-zero default, i.e. a NOP with valid=0. Register indices that the
  // instruction does not use are zeroed so forwarding never matches on
  // immediate bits.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP: begin
        dec.valid = 1'b1; dec.reg_write = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.alu_op = alu_op_decode(funct3, instr_in[30], 1'b1);
      end
      OP_IMM: begin
        dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        uses_rs1 = 1'b1; dec.imm = imm_i;
        dec.alu_op = alu_op_decode(funct3, instr_in[30], 1'b0);
      end
      LOAD: begin
        dec.valid = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
        dec.alu_src = 1'b1; uses_rs1 = 1'b1; dec.imm = imm_i;
      end
      STORE: begin
        dec.valid = 1'b1; dec.mem_write = 1'b1; dec.alu_src = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec.imm = imm_s;
      end
      BRANCH: begin
        dec.valid = 1'b1; dec.branch = 1'b1; dec.alu_op = ALU_SUB;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec.imm = imm_b;
      end
      JAL: begin
        dec.valid = 1'b1; dec.jump = 1'b1; dec.reg_write = 1'b1;
        dec.alu_src = 1'b1; dec.imm = imm_j;
      end
      JALR: begin
        dec.valid = 1'b1; dec.jump = 1'b1; dec.reg_write = 1'b1;
        dec.alu_src = 1'b1; uses_rs1 = 1'b1; dec.imm = imm_i;
      end
      LUI: begin
        dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.alu_op = ALU_COPY_B; dec.imm = imm_u;
      end
      AUIPC: begin
        dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.imm = imm_u;
      end
      default: ;
    endcase
    if (dec.valid) begin
      dec.pc     = pc_in;
      dec.funct3 = funct3;
    end
    dec.rs1 = uses_rs1      ? instr_in[19:15] : '0;
    dec.rs2 = uses_rs2      ? instr_in[24:20] : '0;
    dec.rd  = dec.reg_write ? instr_in[11:7]  : '0;
  end

  reg_file u_reg_file (
    .stage_clk (stage_clk),
    .reset_n   (reset_n),
    .rs1_addr  (dec.rs1),
    .rs1_data  (rs1_data),
    .rs2_addr  (dec.rs2),
    .rs2_data  (rs2_data),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  always_comb begin
    id_ex_next         = dec;
    id_ex_next.rs1_val = rs1_data;
    id_ex_next.rs2_val = rs2_data;
  end

  // A load in EX whose destination feeds this instruction must bubble one
  // cycle. Once the bubble is in, ex_valid=0 drops the request by itself.
  assign hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                        ((uses_rs1 && (ex_q.rd == instr_in[19:15])) ||
                         (uses_rs2 && (ex_q.rd == instr_in[24:20])));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge stage_clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q <= '0;
    end else if (stage_x) begin
      ex_q <= '0;
    end else if (stage_ena) begin
      ex_q <= hazard_stall ? '0 : id_ex_next;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_funct3    = ex_q.funct3;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: expected ID/EX contents are queued when
// an instruction is driven and compared after the capturing edge.
module tb_decode_unit;
  import rv32i_pkg::*;

  logic        stage_clk, reset_n, stage_ena, stage_x;
  logic [31:0] instr_in, pc_in;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump;
  logic [2:0]  ex_funct3;

  int checks = 0;
  int errors = 0;
  id_ex_t exp_q[$];

  localparam logic [4:0] C_MR = 5'b10000;
  localparam logic [4:0] C_MW = 5'b01000;
  localparam logic [4:0] C_RW = 5'b00100;
  localparam logic [4:0] C_BR = 5'b00010;
  localparam logic [4:0] C_J  = 5'b00001;

  localparam logic [31:0] I_ADDI_X1_5  = 32'h00500093;
  localparam logic [31:0] I_ADD_3_2_2  = 32'h002101B3;
  localparam logic [31:0] I_ADD_3_0_0  = 32'h000001B3;
  localparam logic [31:0] I_ADD_4_2_0  = 32'h00010233;
  localparam logic [31:0] I_ADD_4_2_1  = 32'h00110233;
  localparam logic [31:0] I_LW_5_0_1   = 32'h0000A283;
  localparam logic [31:0] I_ADD_6_5_0  = 32'h00028333;
  localparam logic [31:0] I_ADDI_X6_5  = 32'h00500313;
  localparam logic [31:0] I_LUI_7      = 32'h123453B7;
  localparam logic [31:0] I_BEQ_M4     = 32'hFE000EE3;
  localparam logic [31:0] I_JAL_2048   = 32'h001000EF;
  localparam logic [31:0] I_SW_2_8_1   = 32'h0020A423;

  decode_unit dut (
    .stage_clk    (stage_clk),
    .reset_n      (reset_n),
    .stage_ena    (stage_ena),
    .stage_x      (stage_x),
    .instr_in     (instr_in),
    .pc_in        (pc_in),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .hazard_stall (hazard_stall),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_rs1_val   (ex_rs1_val),
    .ex_rs2_val   (ex_rs2_val),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_alu_op    (ex_alu_op),
    .ex_alu_src   (ex_alu_src),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write),
    .ex_branch    (ex_branch),
    .ex_jump      (ex_jump),
    .ex_funct3    (ex_funct3)
  );

  initial begin
    stage_clk = 1'b0;
    forever #5 stage_clk = ~stage_clk;
  end

  task automatic check(input string tag, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic id_ex_t dut_state();
    id_ex_t s;
    s.valid     = ex_valid;
    s.pc        = ex_pc;
    s.rs1_val   = ex_rs1_val;
    s.rs2_val   = ex_rs2_val;
    s.imm       = ex_imm;
    s.rs1       = ex_rs1;
    s.rs2       = ex_rs2;
    s.rd        = ex_rd;
    s.alu_op    = alu_op_e'(ex_alu_op);
    s.alu_src   = ex_alu_src;
    s.mem_read  = ex_mem_read;
    s.mem_write = ex_mem_write;
    s.reg_write = ex_reg_write;
    s.branch    = ex_branch;
    s.jump      = ex_jump;
    s.funct3    = ex_funct3;
    return s;
  endfunction

  function automatic id_ex_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] v1, input logic [31:0] v2,
                                input logic [31:0] imm, input alu_op_e op,
                                input logic src, input logic [2:0] f3,
                                input logic [4:0] ctl);
    id_ex_t e;
    e.valid   = 1'b1;
    e.pc      = pc;
    e.rs1     = rs1;
    e.rs2     = rs2;
    e.rd      = rd;
    e.rs1_val = v1;
    e.rs2_val = v2;
    e.imm     = imm;
    e.alu_op  = op;
    e.alu_src = src;
    e.funct3  = f3;
    {e.mem_read, e.mem_write, e.reg_write, e.branch, e.jump} = ctl;
    return e;
  endfunction

  // Drive one instruction, check the stall request before the edge, then
  // compare the ID/EX register after the edge against the queued expectation.
  task automatic cycle(input string tag, input logic [31:0] instr,
                       input logic [31:0] pc, input logic exp_stall,
                       input id_ex_t exp);
    instr_in = instr;
    pc_in    = pc;
    exp_q.push_back(exp);
    #1;
    check({tag, "_stall"}, 256'(hazard_stall), 256'(exp_stall));
    @(posedge stage_clk);
    #1;
    check(tag, 256'(dut_state()), 256'(exp_q.pop_front()));
    wb_we   = 1'b0;
    stage_x = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    id_ex_t lui_exp;
    reset_n   = 1'b0;
    stage_ena = 1'b0;
    stage_x   = 1'b0;
    instr_in  = '0;
    pc_in     = '0;
    wb_we     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;

    repeat (2) @(posedge stage_clk);
    #1;
    check("reset_state", 256'(dut_state()), 256'(0));
    check("reset_stall", 256'(hazard_stall), 256'(0));
    reset_n   = 1'b1;
    stage_ena = 1'b1;

    // Basic capture with 1-cycle latency.
    cycle("addi", I_ADDI_X1_5, 32'h10, 1'b0,
          mk(32'h10, 0, 0, 1, 0, 0, 32'd5, ALU_ADD, 1'b1, 3'd0, C_RW));

    // Write-through bypass, and x0 never bypassed.
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
    cycle("wt_x2", I_ADD_3_2_2, 32'h14, 1'b0,
          mk(32'h14, 2, 2, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0, ALU_ADD, 1'b0, 3'd0, C_RW));
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    cycle("wt_x0", I_ADD_3_0_0, 32'h18, 1'b0,
          mk(32'h18, 0, 0, 3, 0, 0, 0, ALU_ADD, 1'b0, 3'd0, C_RW));
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h00000100;
    cycle("rf_x2", I_ADD_4_2_0, 32'h1C, 1'b0,
          mk(32'h1C, 2, 0, 4, 32'hDEADBEEF, 0, 0, ALU_ADD, 1'b0, 3'd0, C_RW));

    // Load-use hazard: one bubble, then the dependent add is captured.
    cycle("lw", I_LW_5_0_1, 32'h20, 1'b0,
          mk(32'h20, 1, 0, 5, 32'h100, 0, 0, ALU_ADD, 1'b1, 3'd2, C_MR | C_RW));
    cycle("lu_bubble", I_ADD_6_5_0, 32'h24, 1'b1, '0);
    cycle("lu_retry", I_ADD_6_5_0, 32'h24, 1'b0,
          mk(32'h24, 5, 0, 6, 0, 0, 0, ALU_ADD, 1'b0, 3'd0, C_RW));

    // rs2 field of an I-type matches the load rd but is not a source.
    cycle("lw2", I_LW_5_0_1, 32'h28, 1'b0,
          mk(32'h28, 1, 0, 5, 32'h100, 0, 0, ALU_ADD, 1'b1, 3'd2, C_MR | C_RW));
    cycle("no_rs2_haz", I_ADDI_X6_5, 32'h2C, 1'b0,
          mk(32'h2C, 0, 0, 6, 0, 0, 32'd5, ALU_ADD, 1'b1, 3'd0, C_RW));

    // Flush wins over enable; then hold for 3 edges with stage_ena=0.
    stage_x = 1'b1;
    cycle("flush", I_ADDI_X1_5, 32'h30, 1'b0, '0);
    lui_exp = mk(32'h34, 0, 0, 7, 0, 0, 32'h12345000, ALU_COPY_B, 1'b1, 3'd5, C_RW);
    cycle("lui", I_LUI_7, 32'h34, 1'b0, lui_exp);
    stage_ena = 1'b0;
    for (int i = 0; i < 3; i++) cycle("hold", I_ADD_3_2_2, 32'h38, 1'b0, lui_exp);
    stage_ena = 1'b1;

    // Immediate formats and NOP decodes.
    cycle("beq", I_BEQ_M4, 32'h40, 1'b0,
          mk(32'h40, 0, 0, 0, 0, 0, 32'hFFFFFFFC, ALU_SUB, 1'b0, 3'd0, C_BR));
    cycle("jal", I_JAL_2048, 32'h44, 1'b0,
          mk(32'h44, 0, 0, 1, 0, 0, 32'h00000800, ALU_ADD, 1'b1, 3'd0, C_RW | C_J));
    cycle("nop_zero", 32'h0, 32'h48, 1'b0, '0);
    cycle("sw", I_SW_2_8_1, 32'h4C, 1'b0,
          mk(32'h4C, 1, 2, 0, 32'h100, 32'hDEADBEEF, 32'd8, ALU_ADD, 1'b1, 3'd2, C_MW));
    cycle("unknown", 32'hFFFFFFFF, 32'h50, 1'b0, '0);

    // Reset in the middle of a stall.
    cycle("lw3", I_LW_5_0_1, 32'h54, 1'b0,
          mk(32'h54, 1, 0, 5, 32'h100, 0, 0, ALU_ADD, 1'b1, 3'd2, C_MR | C_RW));
    instr_in = I_ADD_6_5_0;
    pc_in    = 32'h58;
    #1;
    check("pre_rst_stall", 256'(hazard_stall), 256'(1));
    reset_n = 1'b0;
    #1;
    check("mid_rst_stall", 256'(hazard_stall), 256'(0));
    check("mid_rst_state", 256'(dut_state()), 256'(0));
    @(posedge stage_clk);
    #1;
    reset_n = 1'b1;
    cycle("rf_cleared", I_ADD_4_2_1, 32'h60, 1'b0,
          mk(32'h60, 2, 1, 4, 0, 0, 0, ALU_ADD, 1'b0, 3'd0, C_RW));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
